// File: rtl/kitchen_timer_pkg.sv
// rtl/kitchen_timer_pkg.sv - shared state encoding, digit width and BCD limits for the kitchen timer
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  localparam int DIGIT_W   = 4;
  localparam int SEC_LIMIT = 59;
  localparam int MIN_LIMIT = 99;

  function automatic int bcd_val(input logic [DIGIT_W-1:0] tens, input logic [DIGIT_W-1:0] ones);
    return 10 * int'(tens) + int'(ones);
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - MM:SS BCD register with wrap-around increments and a borrowing one-second decrement
module bcd_time_counter
  import kitchen_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc_min,
  input  logic               inc_sec,
  input  logic               dec,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               is_zero
);

  localparam logic [DIGIT_W-1:0] D0 = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] D1 = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] D5 = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] D9 = DIGIT_W'(9);

  logic [DIGIT_W-1:0] mt_q, mo_q, st_q, so_q;
  logic [DIGIT_W-1:0] mt_d, mo_d, st_d, so_d;

  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    if (clr) begin
      mt_d = D0;
      mo_d = D0;
      st_d = D0;
      so_d = D0;
    end else if (dec) begin
      if (so_q != D0) begin
        so_d = so_q - D1;
      end else begin
        so_d = D9;
        if (st_q != D0) begin
          st_d = st_q - D1;
        end else begin
          st_d = D5;
          if (mo_q != D0) begin
            mo_d = mo_q - D1;
          end else begin
            mo_d = D9;
            mt_d = mt_q - D1;
          end
        end
      end
    end else begin
      // Seconds wrap 59->00 on their own; minutes never see a carry.
      if (inc_sec) begin
        if (bcd_val(st_q, so_q) == SEC_LIMIT) begin
          st_d = D0;
          so_d = D0;
        end else if (so_q == D9) begin
          st_d = st_q + D1;
          so_d = D0;
        end else begin
          so_d = so_q + D1;
        end
      end
      if (inc_min) begin
        if (bcd_val(mt_q, mo_q) == MIN_LIMIT) begin
          mt_d = D0;
          mo_d = D0;
        end else if (mo_q == D9) begin
          mt_d = mt_q + D1;
          mo_d = D0;
        end else begin
          mo_d = mo_q + D1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mt_q <= D0;
      mo_q <= D0;
      st_q <= D0;
      so_q <= D0;
    end else begin
      mt_q <= mt_d;
      mo_q <= mo_d;
      st_q <= st_d;
      so_q <= so_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign is_zero  = (mt_q == D0) && (mo_q == D0) && (st_q == D0) && (so_q == D0);

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// rtl/kitchen_timer_ctrl.sv - kitchen timer FSM: ms tick detection, countdown sequencing and alarm timeout
module kitchen_timer_ctrl
  import kitchen_timer_pkg::*;
#(
  parameter int MS_PER_SEC = 1000,
  parameter int ALARM_SEC  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               k_clk,
  input  logic               btn_start,
  input  logic               btn_clr,
  input  logic               btn_min,
  input  logic               btn_sec,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               alarm,
  output logic [1:0]         state
);

  localparam int MS_W  = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam int ALM_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_PER_SEC - 1);
  localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_SEC - 1);

  state_e           state_q, state_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [ALM_W-1:0] alm_q, alm_d;
  logic             k_clk_q, armed_q, running_q, alarm_q;
  logic             ms_tick, sec_due, is_zero, is_one;
  logic             clr_time, inc_min, inc_sec, dec;

  // armed_q masks the spurious edge seen when k_clk is already high as reset releases.
  assign ms_tick = (k_clk ^ k_clk_q) & armed_q;
  assign sec_due = (state_q == ST_RUN) && ms_tick && (ms_q == MS_LAST);
  assign is_one  = ({min_tens, min_ones, sec_tens} == '0) && (sec_ones == DIGIT_W'(1));

  assign clr_time = btn_clr;
  assign dec      = sec_due && !btn_clr && !btn_start;
  assign inc_min  = (state_q == ST_IDLE) && !btn_clr && !btn_start && btn_min;
  assign inc_sec  = (state_q == ST_IDLE) && !btn_clr && !btn_start && btn_sec;

  bcd_time_counter u_time (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_time),
    .inc_min  (inc_min),
    .inc_sec  (inc_sec),
    .dec      (dec),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .is_zero  (is_zero)
  );

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    alm_d   = alm_q;
    unique case (state_q)
      ST_IDLE: begin
        ms_d  = '0;
        alm_d = '0;
        if (!btn_clr && btn_start && !is_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn_clr) begin
          state_d = ST_IDLE;
          ms_d    = '0;
        end else if (btn_start) begin
          state_d = ST_PAUSE;
        end else if (ms_tick) begin
          if (ms_q == MS_LAST) begin
            ms_d = '0;
            if (is_one) begin
              state_d = ST_ALARM;
              alm_d   = '0;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (btn_clr) begin
          state_d = ST_IDLE;
          ms_d    = '0;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (btn_clr || btn_start) begin
          state_d = ST_IDLE;
          ms_d    = '0;
          alm_d   = '0;
        end else if (ms_tick) begin
          if (ms_q == MS_LAST) begin
            ms_d = '0;
            if (alm_q == ALM_LAST) begin
              state_d = ST_IDLE;
              alm_d   = '0;
            end else begin
              alm_d = alm_q + 1'b1;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ms_q      <= '0;
      alm_q     <= '0;
      k_clk_q   <= 1'b0;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      alm_q     <= alm_d;
      k_clk_q   <= k_clk;
      armed_q   <= 1'b1;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
    end
  end

  assign running = running_q;
  assign alarm   = alarm_q;
  assign state   = state_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb/tb_kitchen_timer_ctrl.sv - directed self-checking bench for kitchen_timer_ctrl
module tb_kitchen_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       k_clk = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  kitchen_timer_ctrl #(.MS_PER_SEC(4), .ALARM_SEC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .k_clk     (k_clk),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .btn_min   (btn_min),
    .btn_sec   (btn_sec),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] tm();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // m = {clr, start, min, sec}
  task automatic press(input logic [3:0] m);
    @(posedge clk); #1;
    {btn_clr, btn_start, btn_min, btn_sec} = m;
    @(posedge clk); #1;
    {btn_clr, btn_start, btn_min, btn_sec} = 4'b0000;
  endtask

  task automatic press_n(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      k_clk = ~k_clk;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_time", tm(), 16'h0000);
    chk("rst_state", state, 2'b00);
    chk("rst_running", running, 1'b0);
    chk("rst_alarm", alarm, 1'b0);

    press(4'b0100);
    chk("start_at_zero_state", state, 2'b00);

    press_n(4'b0001, 61);
    chk("sec_x61", tm(), 16'h0001);
    press_n(4'b0010, 99);
    chk("min_x99", tm(), 16'h9901);
    press(4'b0010);
    chk("min_wrap", tm(), 16'h0001);
    press(4'b1000);
    chk("clr_idle", tm(), 16'h0000);

    press(4'b0010);
    press_n(4'b0001, 30);
    chk("set_0130", tm(), 16'h0130);
    press(4'b0100);
    chk("run_state", state, 2'b01);
    chk("run_running", running, 1'b1);
    tick_n(2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_time", tm(), 16'h0000);
    chk("midrst_state", state, 2'b00);
    chk("midrst_running", running, 1'b0);
    chk("midrst_alarm", alarm, 1'b0);
    rst = 1'b0;

    press(4'b0010);
    press(4'b0100);
    tick_n(3);
    chk("0100_before_dec", tm(), 16'h0100);
    tick_n(1);
    chk("0100_borrow", tm(), 16'h0059);
    tick_n(59 * 4 - 1);
    chk("0100_last_sec", tm(), 16'h0001);
    chk("0100_still_run", state, 2'b01);
    tick_n(1);
    chk("0100_alarm_state", state, 2'b11);
    chk("0100_alarm", alarm, 1'b1);
    chk("0100_alarm_time", tm(), 16'h0000);
    press(4'b0100);
    chk("ack_state", state, 2'b00);
    chk("ack_alarm", alarm, 1'b0);

    press_n(4'b0001, 3);
    press(4'b0100);
    tick_n(6);
    chk("p_6ticks", tm(), 16'h0002);
    press(4'b0100);
    chk("p_paused", state, 2'b10);
    chk("p_paused_run", running, 1'b0);
    tick_n(20);
    chk("p_hold_time", tm(), 16'h0002);
    press(4'b0100);
    chk("p_resumed", state, 2'b01);
    tick_n(1);
    chk("p_resume_1", tm(), 16'h0002);
    tick_n(1);
    chk("p_resume_2", tm(), 16'h0001);
    tick_n(4);
    chk("p_alarm_state", state, 2'b11);
    chk("p_alarm", alarm, 1'b1);
    tick_n(7);
    chk("p_alarm_hold", alarm, 1'b1);
    tick_n(1);
    chk("p_timeout_state", state, 2'b00);
    chk("p_timeout_alarm", alarm, 1'b0);

    press_n(4'b0001, 5);
    press(4'b0100);
    tick_n(2);
    press(4'b1100);
    chk("clrstart_state", state, 2'b00);
    chk("clrstart_time", tm(), 16'h0000);

    press(4'b0001);
    press(4'b0100);
    tick_n(3);
    @(posedge clk); #1;
    k_clk = ~k_clk;
    btn_start = 1'b1;
    @(posedge clk); #1;
    btn_start = 1'b0;
    chk("final_dec_pause_state", state, 2'b10);
    chk("final_dec_pause_time", tm(), 16'h0001);
    press(4'b1000);
    chk("final_clr_state", state, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
